// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq
// Purpose  : MIPS-style ALU with a valid/ready handshake on both sides.
//            Single-cycle ops return one cycle after acceptance. mult/multu
//            run an iterative shift-add and return WIDTH+1 cycles after
//            acceptance. Results are written to {hi,lo}.
//            Optional macro ALU_SEQ_DIV_EN adds div/divu (restoring
//            division, same latency as multiply). Without the macro,
//            div/divu are handled as unsupported ops.
// Ports    : clk, rst_n (async, active low)
//            in_valid/in_ready       - operation handshake
//            opcode, ALU_control     - MIPS opcode / funct fields
//            shamt, immediate        - shift amount, raw 16-bit immediate
//            rs_content, rt_content  - operands
//            out_valid/out_ready     - result handshake
//            ALU_result, sig_branch, hi, lo - results
// Revision : 1.0 - initial release
// ============================================================================
module alu_seq #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       opcode,
    input  logic [5:0]       ALU_control,
    input  logic [SHW-1:0]   shamt,
    input  logic [15:0]      immediate,
    input  logic [WIDTH-1:0] rs_content,
    input  logic [WIDTH-1:0] rt_content,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALU_result,
    output logic             sig_branch,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    // Opcodes
    localparam logic [5:0] c_OP_RTYPE = 6'h00;
    localparam logic [5:0] c_OP_BEQ   = 6'h04;
    localparam logic [5:0] c_OP_BNE   = 6'h05;
    localparam logic [5:0] c_OP_ADDI  = 6'h08;
    localparam logic [5:0] c_OP_ADDIU = 6'h09;
    localparam logic [5:0] c_OP_SLTI  = 6'h0A;
    localparam logic [5:0] c_OP_SLTIU = 6'h0B;
    localparam logic [5:0] c_OP_ANDI  = 6'h0C;
    localparam logic [5:0] c_OP_ORI   = 6'h0D;
    localparam logic [5:0] c_OP_LUI   = 6'h0F;
    localparam logic [5:0] c_OP_LW    = 6'h23;
    localparam logic [5:0] c_OP_LBU   = 6'h24;
    localparam logic [5:0] c_OP_LHU   = 6'h25;
    localparam logic [5:0] c_OP_SB    = 6'h28;
    localparam logic [5:0] c_OP_SH    = 6'h29;
    localparam logic [5:0] c_OP_SW    = 6'h2B;
    localparam logic [5:0] c_OP_LL    = 6'h30;

    // R-type funct codes
    localparam logic [5:0] c_FN_SLL   = 6'h00;
    localparam logic [5:0] c_FN_SRL   = 6'h02;
    localparam logic [5:0] c_FN_SRA   = 6'h03;
    localparam logic [5:0] c_FN_MFHI  = 6'h10;
    localparam logic [5:0] c_FN_MTHI  = 6'h11;
    localparam logic [5:0] c_FN_MFLO  = 6'h12;
    localparam logic [5:0] c_FN_MTLO  = 6'h13;
    localparam logic [5:0] c_FN_MULT  = 6'h18;
    localparam logic [5:0] c_FN_MULTU = 6'h19;
`ifdef ALU_SEQ_DIV_EN
    localparam logic [5:0] c_FN_DIV   = 6'h1A;
    localparam logic [5:0] c_FN_DIVU  = 6'h1B;
`endif
    localparam logic [5:0] c_FN_ADD   = 6'h20;
    localparam logic [5:0] c_FN_ADDU  = 6'h21;
    localparam logic [5:0] c_FN_SUB   = 6'h22;
    localparam logic [5:0] c_FN_SUBU  = 6'h23;
    localparam logic [5:0] c_FN_AND   = 6'h24;
    localparam logic [5:0] c_FN_OR    = 6'h25;
    localparam logic [5:0] c_FN_NOR   = 6'h27;
    localparam logic [5:0] c_FN_SLT   = 6'h2A;
    localparam logic [5:0] c_FN_SLTU  = 6'h2B;

    localparam logic [SHW-1:0] c_LAST_ITER = SHW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [SHW-1:0]     r_cnt;
    logic [WIDTH-1:0]   r_result;
    logic               r_branch;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    // Iterative datapath: r_md is multiplicand/divisor, {r_acc_hi,r_acc_lo}
    // is the running product or remainder/quotient pair.
    logic [WIDTH-1:0]   r_md;
    logic [WIDTH-1:0]   r_acc_hi;
    logic [WIDTH-1:0]   r_acc_lo;
    logic               r_neg_lo;   // negate product / quotient at the end

    logic               w_accept;
    logic               w_last;
    logic [WIDTH-1:0]   w_imm_sext;
    logic [WIDTH-1:0]   w_imm_zext;
    logic [WIDTH-1:0]   w_lui;
    logic [WIDTH-1:0]   w_diff;
    logic [WIDTH-1:0]   w_single_res;
    logic               w_branch;
    logic               w_wr_hi;
    logic               w_wr_lo;
    logic               w_is_mult;
    logic               w_is_multi;
    logic               w_signed;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;

    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH-1:0]   w_mul_hi;
    logic [WIDTH-1:0]   w_mul_lo;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_step_hi;
    logic [WIDTH-1:0]   w_step_lo;
    logic [WIDTH-1:0]   w_fin_hi;
    logic [WIDTH-1:0]   w_fin_lo;

`ifdef ALU_SEQ_DIV_EN
    logic               r_is_div;
    logic               r_neg_hi;   // remainder takes the dividend's sign
    logic               w_is_div;
    logic               w_div_zero;
    logic [WIDTH:0]     w_div_shift;
    logic               w_div_ge;
    logic [WIDTH-1:0]   w_div_hi;
    logic [WIDTH-1:0]   w_div_lo;
`endif

    // ------------------------------------------------------------------
    // Immediate extension; lui placement depends on datapath width
    // ------------------------------------------------------------------
    generate
        if (WIDTH > 16) begin : g_imm_wide
            assign w_imm_sext = {{(WIDTH-16){immediate[15]}}, immediate};
            assign w_imm_zext = {{(WIDTH-16){1'b0}}, immediate};
        end else begin : g_imm_narrow
            assign w_imm_sext = immediate;
            assign w_imm_zext = immediate;
        end
        if (WIDTH >= 32) begin : g_lui_wide
            assign w_lui = w_imm_zext << 16;
        end else begin : g_lui_narrow
            assign w_lui = w_imm_zext;
        end
    endgenerate

    assign w_diff = rs_content - rt_content;

    // ------------------------------------------------------------------
    // Decode and single-cycle result
    // ------------------------------------------------------------------
    always_comb begin
        w_single_res = '0;
        w_branch     = 1'b0;
        w_wr_hi      = 1'b0;
        w_wr_lo      = 1'b0;
        w_is_mult    = 1'b0;
        w_signed     = 1'b0;
`ifdef ALU_SEQ_DIV_EN
        w_is_div     = 1'b0;
`endif
        case (opcode)
            c_OP_RTYPE: begin
                case (ALU_control)
                    c_FN_ADD, c_FN_ADDU: w_single_res = rs_content + rt_content;
                    c_FN_SUB, c_FN_SUBU: w_single_res = w_diff;
                    c_FN_AND:   w_single_res = rs_content & rt_content;
                    c_FN_OR:    w_single_res = rs_content | rt_content;
                    c_FN_NOR:   w_single_res = ~(rs_content | rt_content);
                    c_FN_SLL:   w_single_res = rt_content << shamt;
                    c_FN_SRL:   w_single_res = rt_content >> shamt;
                    c_FN_SRA:   w_single_res = $signed(rt_content) >>> shamt;
                    c_FN_SLT:   w_single_res = {{(WIDTH-1){1'b0}},
                                    $signed(rs_content) < $signed(rt_content)};
                    c_FN_SLTU:  w_single_res = {{(WIDTH-1){1'b0}},
                                    rs_content < rt_content};
                    c_FN_MFHI:  w_single_res = r_hi;
                    c_FN_MFLO:  w_single_res = r_lo;
                    c_FN_MTHI:  w_wr_hi = 1'b1;
                    c_FN_MTLO:  w_wr_lo = 1'b1;
                    c_FN_MULT: begin
                        w_is_mult = 1'b1;
                        w_signed  = 1'b1;
                    end
                    c_FN_MULTU: w_is_mult = 1'b1;
`ifdef ALU_SEQ_DIV_EN
                    c_FN_DIV: begin
                        w_is_div = 1'b1;
                        w_signed = 1'b1;
                    end
                    c_FN_DIVU:  w_is_div = 1'b1;
`endif
                    default: ;
                endcase
            end
            c_OP_ADDI, c_OP_ADDIU, c_OP_LW, c_OP_LBU, c_OP_LHU,
            c_OP_SB, c_OP_SH, c_OP_SW, c_OP_LL:
                w_single_res = rs_content + w_imm_sext;
            c_OP_SLTI:  w_single_res = {{(WIDTH-1){1'b0}},
                            $signed(rs_content) < $signed(w_imm_sext)};
            c_OP_SLTIU: w_single_res = {{(WIDTH-1){1'b0}},
                            rs_content < w_imm_sext};
            c_OP_ANDI:  w_single_res = rs_content & w_imm_zext;
            c_OP_ORI:   w_single_res = rs_content | w_imm_zext;
            c_OP_LUI:   w_single_res = w_lui;
            c_OP_BEQ: begin
                w_single_res = w_diff;
                w_branch     = (rs_content == rt_content);
            end
            c_OP_BNE: begin
                w_single_res = w_diff;
                w_branch     = (rs_content != rt_content);
            end
            default: ;
        endcase
    end

`ifdef ALU_SEQ_DIV_EN
    assign w_is_multi = w_is_mult | w_is_div;
    assign w_div_zero = (rt_content == '0);
`else
    assign w_is_multi = w_is_mult;
`endif

    // Signed ops run on magnitudes; the sign is restored on completion.
    assign w_a_neg = w_signed & rs_content[WIDTH-1];
    assign w_b_neg = w_signed & rt_content[WIDTH-1];
    assign w_mag_a = w_a_neg ? (~rs_content + 1'b1) : rs_content;
    assign w_mag_b = w_b_neg ? (~rt_content + 1'b1) : rt_content;

    // ------------------------------------------------------------------
    // One iteration of the shift-add multiplier (and divider)
    // ------------------------------------------------------------------
    assign w_mul_sum  = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_md} : '0);
    assign w_mul_hi   = w_mul_sum[WIDTH:1];
    assign w_mul_lo   = {w_mul_sum[0], r_acc_lo[WIDTH-1:1]};
    assign w_prod     = {w_mul_hi, w_mul_lo};
    assign w_prod_fix = r_neg_lo ? (~w_prod + 1'b1) : w_prod;

`ifdef ALU_SEQ_DIV_EN
    // The partial remainder is always below the divisor, so the
    // difference fits in WIDTH bits whenever the subtraction is taken.
    assign w_div_shift = {r_acc_hi, r_acc_lo[WIDTH-1]};
    assign w_div_ge    = (w_div_shift >= {1'b0, r_md});
    assign w_div_hi    = w_div_ge ? (w_div_shift[WIDTH-1:0] - r_md)
                                  : w_div_shift[WIDTH-1:0];
    assign w_div_lo    = {r_acc_lo[WIDTH-2:0], w_div_ge};
`endif

    always_comb begin
        w_step_hi = w_mul_hi;
        w_step_lo = w_mul_lo;
        w_fin_hi  = w_prod_fix[2*WIDTH-1:WIDTH];
        w_fin_lo  = w_prod_fix[WIDTH-1:0];
`ifdef ALU_SEQ_DIV_EN
        if (r_is_div) begin
            w_step_hi = w_div_hi;
            w_step_lo = w_div_lo;
            w_fin_hi  = r_neg_hi ? (~w_div_hi + 1'b1) : w_div_hi;
            w_fin_lo  = r_neg_lo ? (~w_div_lo + 1'b1) : w_div_lo;
        end
`endif
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    assign in_ready  = rst_n && ((r_state == S_IDLE) ||
                                 ((r_state == S_DONE) && out_ready));
    assign out_valid = (r_state == S_DONE);
    assign w_accept  = in_valid && in_ready;
    assign w_last    = (r_state == S_BUSY) && (r_cnt == c_LAST_ITER);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_state_nxt = w_is_multi ? S_BUSY : S_DONE;
            end
            S_BUSY: begin
                if (w_last) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                if (w_accept)       w_state_nxt = w_is_multi ? S_BUSY : S_DONE;
                else if (out_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_result <= '0;
            r_branch <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_md     <= '0;
            r_acc_hi <= '0;
            r_acc_lo <= '0;
            r_neg_lo <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
            r_is_div <= 1'b0;
            r_neg_hi <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_cnt <= '0;
                if (w_is_multi) begin
                    r_acc_hi <= '0;
`ifdef ALU_SEQ_DIV_EN
                    r_is_div <= w_is_div;
                    if (w_is_div && w_div_zero) begin
                        // Divide by zero: a zero divisor makes every step
                        // subtract, leaving an all-ones quotient and the
                        // raw dividend as remainder.
                        r_md     <= '0;
                        r_acc_lo <= rs_content;
                        r_neg_lo <= 1'b0;
                        r_neg_hi <= 1'b0;
                    end else if (w_is_div) begin
                        r_md     <= w_mag_b;
                        r_acc_lo <= w_mag_a;
                        r_neg_lo <= w_a_neg ^ w_b_neg;
                        r_neg_hi <= w_a_neg;
                    end else begin
                        r_md     <= w_mag_a;
                        r_acc_lo <= w_mag_b;
                        r_neg_lo <= w_a_neg ^ w_b_neg;
                        r_neg_hi <= 1'b0;
                    end
`else
                    r_md     <= w_mag_a;
                    r_acc_lo <= w_mag_b;
                    r_neg_lo <= w_a_neg ^ w_b_neg;
`endif
                end else begin
                    r_result <= w_single_res;
                    r_branch <= w_branch;
                    if (w_wr_hi) r_hi <= rs_content;
                    if (w_wr_lo) r_lo <= rs_content;
                end
            end else if (r_state == S_BUSY) begin
                r_cnt    <= r_cnt + 1'b1;
                r_acc_hi <= w_step_hi;
                r_acc_lo <= w_step_lo;
                if (w_last) begin
                    r_hi     <= w_fin_hi;
                    r_lo     <= w_fin_lo;
                    r_result <= w_fin_lo;
                    r_branch <= 1'b0;
                end
            end
        end
    end

    assign ALU_result = r_result;
    assign sig_branch = r_branch;
    assign hi         = r_hi;
    assign lo         = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_seq
// Purpose  : Self-checking bench for alu_seq. A table of single-cycle
//            vectors plus directed sequences for multiply, hi/lo moves,
//            divide (or its absence), output stall, reset mid-operation
//            and a 16-bit instance with back-to-back issue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready, sig_branch;
    logic [5:0]  opcode, ALU_control;
    logic [4:0]  shamt;
    logic [15:0] immediate;
    logic [31:0] rs_content, rt_content, ALU_result, hi, lo;

    logic        d16_in_valid, d16_in_ready, d16_out_valid, d16_sig_branch;
    logic [5:0]  d16_opcode, d16_funct;
    logic [3:0]  d16_shamt;
    logic [15:0] d16_imm, d16_rs, d16_rt, d16_result, d16_hi, d16_lo;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(32)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .ALU_control(ALU_control),
        .shamt(shamt), .immediate(immediate),
        .rs_content(rs_content), .rt_content(rt_content),
        .out_valid(out_valid), .out_ready(out_ready),
        .ALU_result(ALU_result), .sig_branch(sig_branch),
        .hi(hi), .lo(lo)
    );

    alu_seq #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(d16_in_valid), .in_ready(d16_in_ready),
        .opcode(d16_opcode), .ALU_control(d16_funct),
        .shamt(d16_shamt), .immediate(d16_imm),
        .rs_content(d16_rs), .rt_content(d16_rt),
        .out_valid(d16_out_valid), .out_ready(1'b1),
        .ALU_result(d16_result), .sig_branch(d16_sig_branch),
        .hi(d16_hi), .lo(d16_lo)
    );

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [4:0]  sh;
        logic [15:0] imm;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] exp_res;
        logic        exp_br;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [5:0] op, input logic [5:0] fn,
                                input logic [4:0] sh, input logic [15:0] imm,
                                input logic [31:0] rs, input logic [31:0] rt,
                                input logic [31:0] exp_res, input logic exp_br);
        vec_t v;
        v.op = op; v.fn = fn; v.sh = sh; v.imm = imm;
        v.rs = rs; v.rt = rt; v.exp_res = exp_res; v.exp_br = exp_br;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Offer an op, wait for acceptance, then count cycles until out_valid.
    // Returns on the falling edge where out_valid was first seen.
    task automatic issue(input logic [5:0] op, input logic [5:0] fn,
                         input logic [4:0] sh, input logic [15:0] imm,
                         input logic [31:0] a, input logic [31:0] b,
                         output int lat, output int busy_cnt);
        int w;
        opcode = op; ALU_control = fn; shamt = sh; immediate = imm;
        rs_content = a; rt_content = b;
        in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (w >= 100) check("accept_timeout", 64'(w), 64'(0));
        @(posedge clk);
        @(negedge clk);
        // Scramble inputs: operands must have been captured at acceptance
        in_valid = 1'b0;
        opcode = 6'h3F; ALU_control = 6'h3F;
        rs_content = 32'hDEAD_BEEF; rt_content = 32'h1234_5678;
        lat = 1;
        busy_cnt = 0;
        while (!out_valid && lat < 200) begin
            if (!in_ready) busy_cnt++;
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int lat, bc;
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, bc;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        opcode = '0; ALU_control = '0; shamt = '0; immediate = '0;
        rs_content = '0; rt_content = '0;
        d16_in_valid = 1'b0; d16_opcode = '0; d16_funct = '0; d16_shamt = '0;
        d16_imm = '0; d16_rs = '0; d16_rt = '0;

        // ---------------- vector table ----------------
        vecs.push_back(mk(6'h08, 6'h00, 5'd0,  16'hFFFF, 32'h5,        32'h0,        32'h4,        1'b0)); // addi
        vecs.push_back(mk(6'h00, 6'h20, 5'd0,  16'h0,    32'h1,        32'h2,        32'h3,        1'b0)); // add
        vecs.push_back(mk(6'h00, 6'h22, 5'd0,  16'h0,    32'h5,        32'h7,        32'hFFFFFFFE, 1'b0)); // sub
        vecs.push_back(mk(6'h00, 6'h24, 5'd0,  16'h0,    32'hF0F0,     32'hFF00,     32'hF000,     1'b0)); // and
        vecs.push_back(mk(6'h00, 6'h25, 5'd0,  16'h0,    32'hF0F0,     32'h0F0F,     32'hFFFF,     1'b0)); // or
        vecs.push_back(mk(6'h00, 6'h27, 5'd0,  16'h0,    32'h0,        32'h0,        32'hFFFFFFFF, 1'b0)); // nor
        vecs.push_back(mk(6'h00, 6'h00, 5'd31, 16'h0,    32'h0,        32'h1,        32'h80000000, 1'b0)); // sll
        vecs.push_back(mk(6'h00, 6'h02, 5'd4,  16'h0,    32'h0,        32'h80000000, 32'h08000000, 1'b0)); // srl
        vecs.push_back(mk(6'h00, 6'h03, 5'd4,  16'h0,    32'h0,        32'h80000000, 32'hF8000000, 1'b0)); // sra
        vecs.push_back(mk(6'h00, 6'h2A, 5'd0,  16'h0,    32'hFFFFFFFF, 32'h1,        32'h1,        1'b0)); // slt
        vecs.push_back(mk(6'h00, 6'h2B, 5'd0,  16'h0,    32'hFFFFFFFF, 32'h1,        32'h0,        1'b0)); // sltu
        vecs.push_back(mk(6'h0A, 6'h00, 5'd0,  16'hFFFF, 32'hFFFFFFFE, 32'h0,        32'h1,        1'b0)); // slti
        vecs.push_back(mk(6'h0B, 6'h00, 5'd0,  16'hFFFF, 32'h5,        32'h0,        32'h1,        1'b0)); // sltiu
        vecs.push_back(mk(6'h0C, 6'h00, 5'd0,  16'h8001, 32'hFFFFFFFF, 32'h0,        32'h00008001, 1'b0)); // andi
        vecs.push_back(mk(6'h0D, 6'h00, 5'd0,  16'h8000, 32'h0,        32'h0,        32'h00008000, 1'b0)); // ori
        vecs.push_back(mk(6'h0F, 6'h00, 5'd0,  16'h1234, 32'hFFFFFFFF, 32'h0,        32'h12340000, 1'b0)); // lui
        vecs.push_back(mk(6'h04, 6'h00, 5'd0,  16'h0,    32'h3,        32'h3,        32'h0,        1'b1)); // beq taken
        vecs.push_back(mk(6'h05, 6'h00, 5'd0,  16'h0,    32'h3,        32'h3,        32'h0,        1'b0)); // bne not taken
        vecs.push_back(mk(6'h05, 6'h00, 5'd0,  16'h0,    32'h5,        32'h3,        32'h2,        1'b1)); // bne taken
        vecs.push_back(mk(6'h04, 6'h00, 5'd0,  16'h0,    32'h5,        32'h3,        32'h2,        1'b0)); // beq not taken
        vecs.push_back(mk(6'h23, 6'h00, 5'd0,  16'hFFFC, 32'h1000,     32'h0,        32'h0FFC,     1'b0)); // lw
        vecs.push_back(mk(6'h2B, 6'h00, 5'd0,  16'h0010, 32'h100,      32'h0,        32'h110,      1'b0)); // sw
        vecs.push_back(mk(6'h3F, 6'h00, 5'd0,  16'h1234, 32'h9,        32'h9,        32'h0,        1'b0)); // unsupported

        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        check("rst_in_ready",   in_ready,   0);
        check("rst_out_valid",  out_valid,  0);
        check("rst_result",     ALU_result, 0);
        check("rst_branch",     sig_branch, 0);
        check("rst_hi",         hi,         0);
        check("rst_lo",         lo,         0);
        rst_n = 1'b1;
        #1;
        check("rst_release_in_ready", in_ready, 1);

        // ---------------- table-driven single-cycle ops ----------------
        foreach (vecs[i]) begin
            issue(vecs[i].op, vecs[i].fn, vecs[i].sh, vecs[i].imm,
                  vecs[i].rs, vecs[i].rt, lat, bc);
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'(1));
            check($sformatf("vec%0d_result", i), ALU_result, vecs[i].exp_res);
            check($sformatf("vec%0d_branch", i), sig_branch, vecs[i].exp_br);
        end
        check("singles_hi_untouched", hi, 0);
        check("singles_lo_untouched", lo, 0);

        // ---------------- mult -1 * 3 ----------------
        issue(6'h00, 6'h18, 5'd0, 16'h0, 32'hFFFFFFFF, 32'h3, lat, bc);
        check("mult_latency",   64'(lat), 64'(33));
        check("mult_busy_cyc",  64'(bc),  64'(32));
        check("mult_hi",        hi,         32'hFFFFFFFF);
        check("mult_lo",        lo,         32'hFFFFFFFD);
        check("mult_result",    ALU_result, 32'hFFFFFFFD);
        check("mult_branch",    sig_branch, 0);
        issue(6'h00, 6'h10, 5'd0, 16'h0, 32'h0, 32'h0, lat, bc);
        check("mfhi_latency",   64'(lat), 64'(1));
        check("mfhi_result",    ALU_result, 32'hFFFFFFFF);
        issue(6'h00, 6'h12, 5'd0, 16'h0, 32'h0, 32'h0, lat, bc);
        check("mflo_result",    ALU_result, 32'hFFFFFFFD);

        // ---------------- multu 0xFFFFFFFF * 3 ----------------
        issue(6'h00, 6'h19, 5'd0, 16'h0, 32'hFFFFFFFF, 32'h3, lat, bc);
        check("multu_latency",  64'(lat), 64'(33));
        check("multu_hi",       hi, 32'h2);
        check("multu_lo",       lo, 32'hFFFFFFFD);

        // ---------------- in_valid ignored while BUSY ----------------
        opcode = 6'h00; ALU_control = 6'h19; rs_content = 32'd6; rt_content = 32'd7;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ALU_control = 6'h20; rs_content = 32'd10; rt_content = 32'd20;
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check("busy_ign_latency", 64'(lat), 64'(33));
        check("busy_ign_lo",      lo, 32'd42);
        check("busy_ign_hi",      hi, 32'd0);
        check("busy_ign_result",  ALU_result, 32'd42);
        @(negedge clk);   // pending add taken in DONE, straight back to DONE
        in_valid = 1'b0;
        check("done_to_done_valid",  out_valid, 1);
        check("done_to_done_result", ALU_result, 32'd30);
        check("done_to_done_lo",     lo, 32'd42);

        // ---------------- mthi / mtlo / unsupported ----------------
        issue(6'h00, 6'h11, 5'd0, 16'h0, 32'h0000ABCD, 32'h0, lat, bc);
        check("mthi_latency", 64'(lat), 64'(1));
        check("mthi_hi",      hi, 32'h0000ABCD);
        issue(6'h00, 6'h13, 5'd0, 16'h0, 32'h00001234, 32'h0, lat, bc);
        check("mtlo_lo",      lo, 32'h00001234);
        check("mtlo_hi_kept", hi, 32'h0000ABCD);
        issue(6'h00, 6'h3E, 5'd0, 16'h0, 32'h55, 32'h66, lat, bc);
        check("unsup_fn_result", ALU_result, 0);
        check("unsup_fn_hi",     hi, 32'h0000ABCD);
        check("unsup_fn_lo",     lo, 32'h00001234);

`ifdef ALU_SEQ_DIV_EN
        // ---------------- divide ----------------
        issue(6'h00, 6'h1A, 5'd0, 16'h0, 32'hFFFFFFF9, 32'h2, lat, bc);
        check("div_latency", 64'(lat), 64'(33));
        check("div_m7_2_lo", lo, 32'hFFFFFFFD);
        check("div_m7_2_hi", hi, 32'hFFFFFFFF);
        issue(6'h00, 6'h1A, 5'd0, 16'h0, 32'h7, 32'hFFFFFFFE, lat, bc);
        check("div_7_m2_lo", lo, 32'hFFFFFFFD);
        check("div_7_m2_hi", hi, 32'h1);
        issue(6'h00, 6'h1B, 5'd0, 16'h0, 32'h7, 32'h0, lat, bc);
        check("divu_by0_latency", 64'(lat), 64'(33));
        check("divu_by0_lo", lo, 32'hFFFFFFFF);
        check("divu_by0_hi", hi, 32'h7);
        issue(6'h00, 6'h1A, 5'd0, 16'h0, 32'hFFFFFFF9, 32'h0, lat, bc);
        check("div_by0_lo", lo, 32'hFFFFFFFF);
        check("div_by0_hi", hi, 32'hFFFFFFF9);
        issue(6'h00, 6'h1A, 5'd0, 16'h0, 32'h80000000, 32'hFFFFFFFF, lat, bc);
        check("div_min_lo", lo, 32'h80000000);
        check("div_min_hi", hi, 32'h0);
        issue(6'h00, 6'h1B, 5'd0, 16'h0, 32'd100, 32'd7, lat, bc);
        check("divu_lo", lo, 32'd14);
        check("divu_hi", hi, 32'd2);
`else
        // ---------------- divide absent: unsupported ----------------
        issue(6'h00, 6'h1A, 5'd0, 16'h0, 32'h7, 32'h2, lat, bc);
        check("nodiv_latency", 64'(lat), 64'(1));
        check("nodiv_result",  ALU_result, 0);
        check("nodiv_hi",      hi, 32'h0000ABCD);
        check("nodiv_lo",      lo, 32'h00001234);
`endif

        // ---------------- output stall ----------------
        @(negedge clk);   // drain to IDLE
        issue(6'h05, 6'h00, 5'd0, 16'h0, 32'h3, 32'h3, lat, bc);
        check("bne_eq_branch", sig_branch, 0);
        @(negedge clk);
        out_ready = 1'b0;
        issue(6'h04, 6'h00, 5'd0, 16'h0, 32'h3, 32'h3, lat, bc);
        check("stall_beq_latency", 64'(lat), 64'(1));
        check("stall_beq_branch",  sig_branch, 1);
        for (int k = 0; k < 5; k++) begin
            opcode = 6'h00; ALU_control = 6'h20; rs_content = 32'h1; rt_content = 32'h1;
            in_valid = 1'b1;
            @(negedge clk);
            check($sformatf("stall%0d_valid", k),    out_valid, 1);
            check($sformatf("stall%0d_result", k),   ALU_result, 0);
            check($sformatf("stall%0d_branch", k),   sig_branch, 1);
            check($sformatf("stall%0d_in_ready", k), in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("stall_release_valid", out_valid, 0);

        // ---------------- reset in the middle of multu ----------------
        opcode = 6'h00; ALU_control = 6'h19;
        rs_content = 32'hFFFFFFFF; rt_content = 32'h3;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready",  in_ready,  0);
        check("midrst_hi",        hi, 0);
        check("midrst_lo",        lo, 0);
        check("midrst_result",    ALU_result, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("midrst_release_in_ready", in_ready, 1);
        issue(6'h00, 6'h20, 5'd0, 16'h0, 32'h1, 32'h2, lat, bc);
        check("post_rst_add_latency", 64'(lat), 64'(1));
        check("post_rst_add_result",  ALU_result, 32'h3);
        check("post_rst_hi",          hi, 0);

        // ---------------- WIDTH=16 instance, back-to-back ----------------
        @(negedge clk);
        d16_in_valid = 1'b1;
        d16_opcode = 6'h00; d16_funct = 6'h03; d16_shamt = 4'd4; d16_rt = 16'h8000; d16_rs = 16'h0;
        @(negedge clk);
        check("w16_sra_valid",  d16_out_valid, 1);
        check("w16_sra_result", d16_result, 16'hF800);
        d16_funct = 6'h20; d16_rs = 16'h1; d16_rt = 16'h2;
        @(negedge clk);
        check("w16_b2b_add_valid",  d16_out_valid, 1);
        check("w16_b2b_add_result", d16_result, 16'h3);
        d16_funct = 6'h20; d16_rs = 16'h7FFF; d16_rt = 16'h0002;
        @(negedge clk);
        check("w16_b2b_add2_valid",  d16_out_valid, 1);
        check("w16_b2b_add2_result", d16_result, 16'h8001);
        d16_opcode = 6'h0F; d16_imm = 16'h1234;
        @(negedge clk);
        check("w16_lui_result", d16_result, 16'h1234);
        d16_opcode = 6'h08; d16_imm = 16'hFFFF; d16_rs = 16'h5;
        @(negedge clk);
        check("w16_addi_result", d16_result, 16'h4);
        d16_in_valid = 1'b0;
        @(negedge clk);
        check("w16_idle_valid", d16_out_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width; legal values 16, 32, 64.
REQ-002 SHALL have parameter SHW, default $clog2(WIDTH), shift-amount width.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  in  1  operation offered.
REQ-006 SHALL have port in_ready  out  1  operation accepted when in_valid&&in_ready at a clock edge.
REQ-007 SHALL have ports opcode  in  6 and ALU_control  in  6  MIPS opcode and funct fields.
REQ-008 SHALL have ports shamt  in  SHW and immediate  in  16  shift amount and raw immediate.
REQ-009 SHALL have ports rs_content, rt_content  in  WIDTH  operands.
REQ-010 SHALL have ports out_valid  out  1 and out_ready  in  1  result handshake.
REQ-011 SHALL have ports ALU_result  out  WIDTH, sig_branch  out  1, hi  out  WIDTH, lo  out  WIDTH.

Function
REQ-012 SHALL support the single-cycle ops: R-type add, addu, sub, subu, and, or, nor, sll, srl, sra, slt, sltu; I-type addi, addiu, andi, ori, lui, slti, sltiu, beq, bne, and address add (lw, lbu, lhu, sb, sh, sw, ll).
REQ-013 SHALL sign-extend immediate to WIDTH for arithmetic/compare/address ops; zero-extend for andi/ori; lui SHALL place immediate in bits [31:16] (WIDTH>=32) with zero low half, and in bits [15:0] with WIDTH=16.
REQ-014 SHALL register results: single-cycle ops raise out_valid exactly 1 cycle after acceptance.
REQ-015 SHALL drive sig_branch=1 for beq when rs==rt, bne when rs!=rt, ALU_result = rs-rt; sig_branch=0 for every non-branch op.
REQ-016 SHALL support mult (funct 0x18), multu (0x19): iterative shift-add, {hi,lo} = 2*WIDTH-bit product; out_valid WIDTH+1 cycles after acceptance; ALU_result = lo.
REQ-017 SHALL support mfhi (0x10), mflo (0x12): ALU_result = hi / lo, latency 1; mthi (0x11), mtlo (0x13): write rs to hi / lo, latency 1.
REQ-018 SHALL use FSM IDLE -> (multi-cycle op accepted) BUSY -> (iteration counter = WIDTH-1) DONE; IDLE -> (single-cycle op) DONE; DONE -> (out_ready) IDLE, or straight to BUSY/DONE if a new op is accepted same cycle.
REQ-019 SHALL assert in_ready in IDLE, and in DONE only while out_ready=1; deassert in BUSY.
REQ-020 SHALL hold ALU_result, sig_branch, hi, lo and out_valid stable while out_valid=1 and out_ready=0.
REQ-021 SHALL treat unsupported opcode/funct as accepted with ALU_result=0, sig_branch=0, hi/lo unchanged, latency 1.
REQ-022 SHALL keep hi/lo unchanged except by mult/div/mthi/mtlo completion.
REQ-023 SHALL ignore in_valid while BUSY; operands captured at acceptance; later input changes have no effect.

Reset
REQ-024 SHALL, on rst_n=0 at any time including mid-BUSY, immediately force state IDLE, counter 0, out_valid=0, in_ready=0 while asserted, ALU_result=0, sig_branch=0, hi=0, lo=0, aborting any operation.
REQ-025 SHALL assert in_ready in the first cycle after rst_n deasserts.

Configuration
REQ-026 SHALL, with macro ALU_SEQ_DIV_EN defined, support div (0x1A), divu (0x1B): restoring division, lo=quotient, hi=remainder, latency WIDTH+1, signed quotient truncated toward zero, remainder sign of dividend.
REQ-027 SHALL, with ALU_SEQ_DIV_EN defined, on divide-by-zero set lo=all ones, hi=rs; signed MIN/-1 SHALL give lo=MIN, hi=0; both at normal latency.
REQ-028 SHALL, without ALU_SEQ_DIV_EN, treat div/divu as unsupported per REQ-021 and synthesise no divider logic.

Verification
REQ-029 SHALL cover: WIDTH=32, addi rs=0x00000005 imm=0xFFFF -> out_valid after 1 cycle, ALU_result=0x00000004, sig_branch=0.
REQ-030 SHALL cover: mult rs=0xFFFFFFFF (-1), rt=0x00000003 -> in_ready low 32 cycles, out_valid at cycle 33, hi=0xFFFFFFFF, lo=0xFFFFFFFD; then mfhi -> 0xFFFFFFFF.
REQ-031 SHALL cover: with ALU_SEQ_DIV_EN, div rs=-7 rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; divu rs=7 rt=0 -> lo=0xFFFFFFFF, hi=7.
REQ-032 SHALL cover: bne rs=3 rt=3 -> sig_branch=0; beq rs=3 rt=3 -> sig_branch=1; out_ready held 0 for 5 cycles -> outputs stable, in_ready=0.
REQ-033 SHALL cover: rst_n pulsed low at cycle 10 of multu -> out_valid=0, hi=lo=0 immediately; next add 1+2 -> 3 after 1 cycle.
REQ-034 SHALL cover: WIDTH=16, sra rt=0x8000 shamt=4 -> 0xF800; back-to-back add ops with out_ready=1 -> one result per cycle.
